// File: rtl/mvau_defn.sv
// Shared MVAU definitions: default geometry, sf_cnt width rule and activation word type.
package mvau_defn;

    function automatic int sfWidth(input int sf);
        return (sf > 1) ? $clog2(sf) : 1;
    endfunction

    localparam int MVAU_SIMD = 2;
    localparam int MVAU_TI   = 4;
    localparam int MVAU_SF   = 8;
    localparam int MVAU_SF_T = sfWidth(MVAU_SF);

    typedef logic [0:MVAU_SIMD-1][MVAU_TI-1:0] act_word_t;

endpackage

// File: rtl/mvau_inp_buffer_if.sv
// Handshake and data bundle between the control block, the input buffer and the PE array.
interface mvau_inp_buffer_if #(
    parameter int SIMD = 2,
    parameter int TI   = 4,
    parameter int SF_T = 3
);
    logic                 in_v;
    logic [SIMD*TI-1:0]   in_data;
    logic                 ib_wen;
    logic                 ib_ren;
    logic [SF_T-1:0]      sf_cnt;
    logic                 in_rdy;
    logic                 out_v;
    logic [SIMD*TI-1:0]   out_act;
    logic                 err;

    modport master (
        output in_v, in_data, ib_wen, ib_ren, sf_cnt,
        input  in_rdy, out_v, out_act, err
    );

    modport slave (
        input  in_v, in_data, ib_wen, ib_ren, sf_cnt,
        output in_rdy, out_v, out_act, err
    );

endinterface

// File: rtl/mvau_ib_mem.sv
// Input buffer storage: one synchronous write port, one combinational read port, no reset.
module mvau_ib_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
)(
    input  logic             clk,
    input  logic             wen_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/mvau_inp_buffer.sv
// MVAU input activation buffer: records the first tile row's vector and replays it for later rows.
// Optional sticky protocol error flag built only when MVAU_IB_ERRCHK_EN is defined.
module mvau_inp_buffer
    import mvau_defn::*;
#(
    parameter int SIMD = MVAU_SIMD,
    parameter int TI   = MVAU_TI,
    parameter int SF   = MVAU_SF,
    parameter int SF_T = sfWidth(SF)
)(
    input  logic             clk,
    input  logic             rst_n,
    mvau_inp_buffer_if.slave bus
);

    localparam int W = SIMD * TI;

    logic [31:0]   sfCntExt;
    logic          inRange;
    logic          wrAccept;
    logic          rdAccept;
    logic [W-1:0]  rdData;
    logic          outVD,   outVQ;
    logic [W-1:0]  outActD, outActQ;

    assign bus.in_rdy = bus.ib_wen;

    assign sfCntExt = 32'(bus.sf_cnt);
    assign inRange  = sfCntExt < 32'(SF);
    // Write pass always wins over replay, so the memory never sees a same-address read/write.
    assign wrAccept = bus.ib_wen & bus.in_v & inRange;
    assign rdAccept = bus.ib_ren & ~bus.ib_wen & inRange;

    mvau_ib_mem #(
        .WIDTH (W),
        .DEPTH (SF),
        .AW    (SF_T)
    ) u_mem (
        .clk     (clk),
        .wen_i   (wrAccept & rst_n),
        .waddr_i (bus.sf_cnt),
        .wdata_i (bus.in_data),
        .raddr_i (bus.sf_cnt),
        .rdata_o (rdData)
    );

    always_comb begin
        outVD   = 1'b0;
        outActD = outActQ;
        if (wrAccept) begin
            outVD   = 1'b1;
            outActD = bus.in_data;
        end else if (rdAccept) begin
            outVD   = 1'b1;
            outActD = rdData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outVQ   <= 1'b0;
            outActQ <= '0;
        end else begin
            outVQ   <= outVD;
            outActQ <= outActD;
        end
    end

    assign bus.out_v   = outVQ;
    assign bus.out_act = outActQ;

`ifdef MVAU_IB_ERRCHK_EN
    logic underrun;
    logic rangeErr;
    logic errD, errQ;

    // Underrun: control asked for a write-pass word that upstream did not supply.
    assign underrun = bus.ib_wen & ~bus.in_v;
    assign rangeErr = (bus.ib_wen | bus.ib_ren) & ~inRange;

    always_comb begin
        errD = errQ | underrun | rangeErr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            errQ <= 1'b0;
        end else begin
            errQ <= errD;
        end
    end

    assign bus.err = errQ;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mvau_inp_buffer.sv
// Self-checking bench for mvau_inp_buffer: directed scenarios then random traffic against a reference model.
module tb_mvau_inp_buffer;

    localparam int SIMD = 2;
    localparam int TI   = 4;
    localparam int SF   = 8;
    localparam int SF_T = 3;
    localparam int W    = SIMD * TI;
`ifdef MVAU_IB_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mvau_inp_buffer_if #(.SIMD(SIMD), .TI(TI), .SF_T(SF_T)) ibIf ();

    mvau_inp_buffer #(
        .SIMD (SIMD),
        .TI   (TI),
        .SF   (SF),
        .SF_T (SF_T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ibIf)
    );

    logic [W-1:0] refMem [SF];
    logic         refV;
    logic [W-1:0] refAct;
    logic         refErr;

    int errorCount = 0;
    int checkCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; the model predicts what the outputs hold after the edge.
    task automatic applyStimulus(input bit rst, input bit wen, input bit ren, input bit v,
                                 input int cnt, input logic [W-1:0] data, input string tag);
        rst_n          = ~rst;
        ibIf.ib_wen    = wen;
        ibIf.ib_ren    = ren;
        ibIf.in_v      = v;
        ibIf.sf_cnt    = SF_T'(cnt);
        ibIf.in_data   = data;
        #1;
        checkOutput({tag, " in_rdy"}, 32'(ibIf.in_rdy), 32'(wen));

        if (rst) begin
            refV   = 1'b0;
            refAct = '0;
            refErr = 1'b0;
        end else if (wen) begin
            if (v) begin
                refMem[cnt] = data;
                refV        = 1'b1;
                refAct      = data;
            end else begin
                refV = 1'b0;
                if (ERRCHK) refErr = 1'b1;
            end
        end else if (ren) begin
            refV   = 1'b1;
            refAct = refMem[cnt];
        end else begin
            refV = 1'b0;
        end

        @(posedge clk);
        #1;
        checkOutput({tag, " out_v"},   32'(ibIf.out_v),   32'(refV));
        checkOutput({tag, " out_act"}, 32'(ibIf.out_act), 32'(refAct));
        checkOutput({tag, " err"},     32'(ibIf.err),     32'(refErr));
    endtask

    initial begin
        refV   = 1'b0;
        refAct = '0;
        refErr = 1'b0;
        ibIf.ib_wen  = 1'b0;
        ibIf.ib_ren  = 1'b0;
        ibIf.in_v    = 1'b0;
        ibIf.sf_cnt  = '0;
        ibIf.in_data = '0;

        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 8'h00, "reset");

        for (int i = 0; i < SF; i++) applyStimulus(0, 1, 0, 1, i, W'(8'h10 + i), "write");

        for (int p = 0; p < 3; p++)
            for (int i = 0; i < SF; i++) applyStimulus(0, 0, 1, 0, i, 8'h00, "replay");

        applyStimulus(0, 1, 0, 0, 3, 8'h5A, "underrun");
        applyStimulus(0, 0, 1, 0, 3, 8'h00, "underrun_readback");
        applyStimulus(0, 0, 0, 0, 0, 8'h00, "idle_hold");

        applyStimulus(0, 1, 1, 1, 2, 8'hAA, "conflict");
        applyStimulus(0, 0, 1, 0, 2, 8'h00, "conflict_readback");

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, i, W'(8'h30 + i), "midpass_write");
        applyStimulus(1, 1, 0, 1, 4, 8'h34, "midpass_reset");
        for (int i = 0; i < SF; i++) applyStimulus(0, 1, 0, 1, i, W'(8'h20 + i), "rewrite");
        for (int i = 0; i < SF; i++) applyStimulus(0, 0, 1, 0, i, 8'h00, "rewrite_replay");

        for (int n = 0; n < 300; n++) begin
            bit rst, wen, ren, v;
            rst = ($urandom_range(0, 99) < 3);
            wen = rst ? 1'b0 : 1'($urandom_range(0, 1));
            ren = rst ? 1'b0 : 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 9) != 0);
            applyStimulus(rst, wen, ren, v, int'($urandom_range(0, SF - 1)),
                          W'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mvau_inp_buffer.md
MVAU_INP_BUFFER -- requirements
Module: mvau_inp_buffer

Interface
REQ-001 SHALL have parameter SIMD, default 2: activation lanes per word.
REQ-002 SHALL have parameter TI, default 4: bits per activation lane.
REQ-003 SHALL have parameter SF, default 8: words per input vector (buffer depth).
REQ-004 SHALL have parameter SF_T, default 3: sf_cnt width, equal to $clog2(SF) with a minimum of 1.
REQ-005 SHALL have port clk, input, 1 bit: clock, all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port in_v, input, 1 bit: input activation word valid.
REQ-008 SHALL have port in_data, input, SIMD*TI bits: input activation word, lane i at bits [i*TI +: TI].
REQ-009 SHALL have port ib_wen, input, 1 bit: write pass (first NF tile row), from the control block.
REQ-010 SHALL have port ib_ren, input, 1 bit: replay pass, from the control block.
REQ-011 SHALL have port sf_cnt, input, SF_T bits: word address, from the control block.
REQ-012 SHALL have port in_rdy, output, 1 bit: buffer accepts in_data this cycle.
REQ-013 SHALL have port out_v, output, 1 bit: out_act valid.
REQ-014 SHALL have port out_act, output, SIMD*TI bits: activation word to the PE array.
REQ-015 SHALL have port err, output, 1 bit: sticky protocol error flag.

Function
REQ-016 in_rdy SHALL equal ib_wen combinationally.
REQ-017 The block SHALL write: when ib_wen & in_v, in_data is stored at mem[sf_cnt] on the clock edge.
REQ-018 When ib_wen=1, out_act SHALL be driven one cycle later with in_data (write-through, no memory read).
REQ-019 When ib_ren=1, out_act SHALL be driven one cycle later with mem[sf_cnt] as sampled at that edge.
REQ-020 Latency SHALL be exactly 1 cycle: out_act and out_v are registered, with no combinational path from inputs to outputs other than in_rdy.
REQ-021 out_v SHALL be set next cycle to (ib_wen & in_v) | (ib_ren & ~ib_wen).
REQ-022 If ib_wen and ib_ren are both 1, ib_wen SHALL win: write plus write-through, no read.
REQ-023 If neither ib_wen nor ib_ren is 1, out_v SHALL go 0 next cycle and out_act SHALL hold its previous value.
REQ-024 If ib_wen=1 and in_v=0, nothing SHALL be written, out_v SHALL go 0, and the underrun condition SHALL be raised.
REQ-025 A write and a read of the same address in the same cycle cannot occur (REQ-022); no bypass logic SHALL be added for it.
REQ-026 sf_cnt values of SF or above SHALL be ignored: no write, out_v=0, and the range condition SHALL be raised.
REQ-027 sf_cnt wrap from SF-1 to 0 SHALL need no special handling.
REQ-028 Buffer contents SHALL persist across all replay passes until overwritten by the next write pass.

Reset
REQ-029 On rst_n=0 at a clock edge: out_v=0, out_act=0 and err=0.
REQ-030 Memory contents SHALL NOT be reset; after reset, out_v stays 0 until the first accepted write or read.
REQ-031 A reset in the middle of a pass SHALL abort that pass; the next write pass overwrites the stale data.

Configuration
REQ-032 With macro MVAU_IB_ERRCHK_EN defined, err SHALL be set on the cycle after an underrun or range condition and held until reset.
REQ-033 Without MVAU_IB_ERRCHK_EN, err SHALL be tied to 0, no check logic SHALL be built, and all other behaviour SHALL be unchanged.

Structure
REQ-034 SIMD, TI, SF and the SF_T derivation SHALL come from the shared definitions file mvau_defn.sv.
REQ-035 The activation word typedef SHALL be defined in mvau_defn.sv as logic [0:SIMD-1][TI-1:0].
REQ-036 Storage SHALL be one sub-module, mvau_ib_mem: SF x SIMD*TI, 1 write and 1 read port, synchronous write, combinational read, no reset.
REQ-037 Output registers and error logic SHALL live in the top level.

Verification
REQ-038 Reset: rst_n=0 for 2 cycles -> out_v=0, out_act=0, err=0.
REQ-039 Write pass: SF=8, SIMD=2, TI=4, ib_wen=1, in_v=1, sf_cnt=0..7, in_data=8'h10..8'h17 -> out_act=8'h10..8'h17 one cycle later each, out_v=1.
REQ-040 Replay: after the write pass, ib_ren=1 and sf_cnt=0..7 for 3 passes -> out_act=8'h10..8'h17 repeated 3 times, no gaps.
REQ-041 Underrun: ib_wen=1, in_v=0 at sf_cnt=3 -> mem[3] unchanged, out_v=0 next cycle, err=1 (macro on) or err=0 (macro off).
REQ-042 Conflict: ib_wen=1, ib_ren=1, in_data=8'hAA at sf_cnt=2 -> mem[2]=8'hAA and out_act=8'hAA.
REQ-043 Mid-pass reset: rst_n=0 at sf_cnt=4 of a write pass -> out_v=0, then a fresh write pass of 8'h20..8'h27 replays correctly.
